// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - panel geometry and scan-state encoding; HUB75_GHOST_BLANK_EN adds ST_BLANK
package pong_pkg;
  localparam int MATRIX_W  = 64;
  localparam int MATRIX_H  = 64;
  localparam int SCAN_ROWS = 32;
  localparam int COL_W     = $clog2(MATRIX_W);
  localparam int ROW_W     = $clog2(SCAN_ROWS);

`ifdef HUB75_GHOST_BLANK_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_WAIT, ST_LATCH, ST_BLANK} scan_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT, ST_LATCH} scan_state_t;
`endif
endpackage

// File: rtl/hub75_shift_ctrl.sv
// rtl/hub75_shift_ctrl.sv - three-phase column sequencer: address, capture pixel pair, pulse hub_clk
module hub75_shift_ctrl
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             fb_rdata_top,
  input  logic             fb_rdata_bot,
  output logic [COL_W-1:0] col,
  output logic             hub_r1,
  output logic             hub_r2,
  output logic             hub_clk,
  output logic             row_done
);
  logic [1:0] phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= 2'd0;
      col    <= '0;
      hub_r1 <= 1'b0;
      hub_r2 <= 1'b0;
    end else if (run) begin
      if (phase == 2'd2) begin
        phase <= 2'd0;
        col   <= col + COL_W'(1);  // natural wrap 63 -> 0 ends the row
      end else begin
        phase <= phase + 2'd1;
      end
      if (phase == 2'd1) begin
        hub_r1 <= fb_rdata_top;
        hub_r2 <= fb_rdata_bot;
      end
    end else begin
      phase <= 2'd0;
      col   <= '0;
    end
  end

  assign hub_clk  = run && (phase == 2'd2);
  assign row_done = hub_clk && (col == COL_W'(MATRIX_W - 1));
endmodule

// File: rtl/hub75_scanout.sv
// rtl/hub75_scanout.sv - HUB75 1/32-scan FSM with dwell timing; HUB75_GHOST_BLANK_EN adds ghost blanking
module hub75_scanout
  import pong_pkg::*;
#(
  parameter int DWELL     = 256,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [10:0] fb_addr,
  input  logic        fb_rdata_top,
  input  logic        fb_rdata_bot,
  output logic        hub_r1,
  output logic        hub_r2,
  output logic        hub_clk,
  output logic        hub_lat,
  output logic        hub_oe_n,
  output logic [4:0]  hub_addr,
  output logic        frame_done
);
  if (DWELL < 192 || DWELL > 4095 || BLANK_CYC < 1 || BLANK_CYC > 15 ||
      MATRIX_H != 2 * SCAN_ROWS) begin : g_cfg_check
    $error("hub75_scanout: illegal configuration");
  end

  localparam logic [11:0] DWELL_LAST = 12'(DWELL - 1);

  scan_state_t      state, state_next;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [11:0]      dwell_cnt;
  logic             first_row, stop_req, row_done, dwell_met, shift_run, scanning;

`ifdef HUB75_GHOST_BLANK_EN
  localparam logic [3:0]  BLANK_LAST = 4'(BLANK_CYC - 1);
  localparam scan_state_t ST_PRE_LATCH = ST_BLANK;
  logic [3:0] blank_cnt;
  logic       post_blank;
`else
  localparam scan_state_t ST_PRE_LATCH = ST_LATCH;
`endif

  hub75_shift_ctrl u_shift (
    .clk          (clk),
    .rst          (rst),
    .run          (shift_run),
    .fb_rdata_top (fb_rdata_top),
    .fb_rdata_bot (fb_rdata_bot),
    .col          (col),
    .hub_r1       (hub_r1),
    .hub_r2       (hub_r2),
    .hub_clk      (hub_clk),
    .row_done     (row_done)
  );

  assign fb_addr   = {row, col};
  // The first row after IDLE has nothing lit yet, so it skips the dwell wait.
  assign dwell_met = first_row || (dwell_cnt >= DWELL_LAST);
  assign scanning  = (state != ST_IDLE) && (state != ST_LATCH);

  always_comb begin
    state_next = state;
    shift_run  = 1'b0;
    hub_lat    = 1'b0;
    case (state)
      ST_IDLE:  if (enable) state_next = ST_SHIFT;
      ST_SHIFT: begin
        shift_run = 1'b1;
        if (row_done) state_next = dwell_met ? ST_PRE_LATCH : ST_WAIT;
      end
      ST_WAIT:  if (dwell_met) state_next = ST_PRE_LATCH;
`ifdef HUB75_GHOST_BLANK_EN
      ST_BLANK: if (blank_cnt == BLANK_LAST) state_next = ST_LATCH;
`endif
      ST_LATCH: begin
        hub_lat    = 1'b1;
        state_next = (stop_req || !enable) ? ST_IDLE : ST_SHIFT;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row        <= '0;
      dwell_cnt  <= '0;
      first_row  <= 1'b1;
      stop_req   <= 1'b0;
      hub_oe_n   <= 1'b1;
      hub_addr   <= '0;
      frame_done <= 1'b0;
`ifdef HUB75_GHOST_BLANK_EN
      blank_cnt  <= '0;
      post_blank <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      frame_done <= 1'b0;
      if (dwell_cnt != 12'hFFF) dwell_cnt <= dwell_cnt + 12'd1;
      if (scanning && !enable) stop_req <= 1'b1;
      // Row select only moves while the panel is dark.
      if (state_next == ST_LATCH) begin
        hub_oe_n <= 1'b1;
        hub_addr <= row;
      end
      case (state)
        ST_IDLE: begin
          row       <= '0;
          dwell_cnt <= '0;
          first_row <= 1'b1;
          stop_req  <= 1'b0;
          hub_oe_n  <= 1'b1;
        end
        ST_LATCH: begin
          first_row  <= 1'b0;
          frame_done <= (row == ROW_W'(SCAN_ROWS - 1));
          dwell_cnt  <= '0;
          if (state_next == ST_IDLE) begin
            row <= '0;
          end else begin
            row <= row + ROW_W'(1);
`ifdef HUB75_GHOST_BLANK_EN
            post_blank <= 1'b1;
            blank_cnt  <= '0;
`else
            hub_oe_n   <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
`ifdef HUB75_GHOST_BLANK_EN
      if (state_next == ST_BLANK) begin
        hub_oe_n  <= 1'b1;
        blank_cnt <= (state == ST_BLANK) ? blank_cnt + 4'd1 : 4'd0;
      end
      // Post-latch dark period overlaps the next row's shifting; dwell starts when it ends.
      if (post_blank) begin
        blank_cnt <= blank_cnt + 4'd1;
        if (blank_cnt == BLANK_LAST) begin
          post_blank <= 1'b0;
          hub_oe_n   <= 1'b0;
          dwell_cnt  <= '0;
        end
      end
`endif
    end
  end
endmodule

// File: doc/hub75_scanout.md
HUB75_SCANOUT -- requirements
Module: hub75_scanout

Interface
REQ-001 SHALL have parameter DWELL, default 256: minimum hub_oe_n-low cycles per row, measured from the cycle after LATCH; legal range 192..4095.
REQ-002 SHALL have parameter BLANK_CYC, default 4: ghost-blank length, used only under REQ-021; legal range 1..15.
REQ-003 SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  scan-run request
- fb_addr  out  11  frame-buffer read address {row[4:0], col[5:0]}
- fb_rdata_top  in  1  pixel at (row, col), 1-cycle read latency
- fb_rdata_bot  in  1  pixel at (row+32, col), 1-cycle read latency
- hub_r1  out  1  upper-half serial data
- hub_r2  out  1  lower-half serial data
- hub_clk  out  1  panel shift clock
- hub_lat  out  1  panel latch strobe
- hub_oe_n  out  1  panel output enable, active low
- hub_addr  out  5  panel row select
- frame_done  out  1  one-cycle pulse when a frame completes

Function
REQ-005 Panel SHALL be 64x64 at 1/32 scan; row r drives matrix rows r and r+32.
REQ-006 States SHALL be IDLE, SHIFT, WAIT, LATCH, plus BLANK when REQ-021 applies.
REQ-007 IDLE SHALL hold hub_oe_n=1, hub_clk=0 and hub_lat=0; enable=1 SHALL move to SHIFT with row=0 and col=0.
REQ-008 SHIFT SHALL spend 3 cycles per column:
- ph0: fb_addr={row,col}, hub_clk=0.
- ph1: register fb_rdata_top to hub_r1 and fb_rdata_bot to hub_r2, hub_clk=0.
- ph2: hub_clk=1.
REQ-009 A row SHALL take exactly 192 SHIFT cycles, col 0..63, and col SHALL wrap to 0 at the end of the row.
REQ-010 During SHIFT, hub_oe_n SHALL keep its prior value, so the previously latched row stays lit.
REQ-011 After SHIFT, WAIT SHALL hold until dwell_cnt >= DWELL-1; on the first row after IDLE, WAIT SHALL exit immediately.
REQ-012 LATCH SHALL last 1 cycle with hub_oe_n=1, hub_lat=1 and hub_addr<=row.
REQ-013 In the cycle after LATCH:
- hub_oe_n=0, dwell_cnt=0.
- row<=row+1, wrapping 31->0.
- frame_done=1 on the wrap only.
REQ-014 dwell_cnt SHALL be 12 bits and saturate at 4095.
REQ-015 If enable=0 during SHIFT or WAIT, the current row SHALL complete through LATCH and then enter IDLE with hub_oe_n=1 and row=0.
REQ-016 If enable=0 is seen in LATCH, the block SHALL enter IDLE without a further SHIFT.
REQ-017 hub_lat and hub_clk SHALL never be 1 in the same cycle.

Reset
REQ-018 On rst=1 the block SHALL enter IDLE with row=0, col=0, phase=0 and dwell_cnt=0.
REQ-019 Reset values SHALL be: hub_oe_n=1, hub_r1=hub_r2=hub_clk=hub_lat=0, hub_addr=0, fb_addr=0, frame_done=0.
REQ-020 rst SHALL take priority over enable in every state, including mid-SHIFT and LATCH.

Configuration
REQ-021 With HUB75_GHOST_BLANK_EN defined:
- WAIT SHALL pass to BLANK, which holds hub_oe_n=1 for BLANK_CYC cycles before LATCH.
- After LATCH, hub_oe_n SHALL stay 1 for a further BLANK_CYC cycles while SHIFT proceeds, then go to 0.
- dwell_cnt SHALL count from that 1->0 edge.
REQ-022 Without HUB75_GHOST_BLANK_EN, the BLANK state and its counter SHALL be absent, and timing SHALL be exactly REQ-011..REQ-013.

Structure
REQ-023 Package pong_pkg SHALL hold MATRIX_W=64, MATRIX_H=64, SCAN_ROWS=32 and the scan-state enum.
REQ-024 The column/phase sequencer of REQ-008..REQ-009 SHALL be a sub-module, hub75_shift_ctrl; the FSM and dwell/blank timing SHALL stay in hub75_scanout.

Verification
REQ-025 Reset then enable=1 with a frame-buffer model (top=col[0], bot=~col[0]): expect hub_r1=0,1,0,1... and hub_r2 its inverse, 64 hub_clk pulses, hub_lat at cycle 193 after enable, hub_addr=0.
REQ-026 Free run with DWELL=256: expect hub_oe_n low for exactly 256 cycles per row from row 1 on, and frame_done pulsed once every 32 latches with hub_addr wrapping 31->0.
REQ-027 Drop enable at col 10 of row 5: expect row 5 to finish and latch, then IDLE with hub_oe_n=1, and no further hub_clk pulses.
REQ-028 Assert rst at phase 1, col 40: expect all outputs at reset values the next cycle, and restart from row 0 after rst drops.
REQ-029 With HUB75_GHOST_BLANK_EN and BLANK_CYC=4: expect hub_oe_n=1 for 4 cycles before hub_lat, and 4 cycles after it before going low.
REQ-030 Assertion for all runs: hub_oe_n=1 in every cycle where hub_addr changes or hub_lat=1.
